pi_switch_node: RTL and testbench



---
 rtl/pi_switch_node.sv | 190 +++++++++++++++++++
 tb/tb_pi_switch_node.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_switch_node.sv
// Registered pi-switch node for a butterfly-fat-tree NoC using bufferless deflection routing.
// Optional build macro PI_DEFLECT_STATS_EN enables the saturating deflection counter.
module pi_switch_node #(
  parameter int          D_W       = 32,
  parameter int          A_W       = 8,
  parameter int          LEVEL     = 1,
  parameter int          POS       = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [D_W+A_W:0] l_in,
  input  logic [D_W+A_W:0] r_in,
  input  logic [D_W+A_W:0] ul_in,
  input  logic [D_W+A_W:0] ur_in,
  output logic [D_W+A_W:0] l_out,
  output logic [D_W+A_W:0] r_out,
  output logic [D_W+A_W:0] ul_out,
  output logic [D_W+A_W:0] ur_out,
  output logic             rnd,
  output logic [15:0]      deflect_cnt
);

  localparam int P_W = 1 + A_W + D_W;

  typedef enum logic [1:0] {
    DIR_VOID  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Input index: 0=l, 1=r, 2=ul, 3=ur.  Output index: 0=L, 1=R, 2=U1, 3=U2.
  logic [P_W-1:0] in_pkt [4];
  dir_t           dir    [4];
  logic [3:0]     is_up;

  assign in_pkt[0] = l_in;
  assign in_pkt[1] = r_in;
  assign in_pkt[2] = ul_in;
  assign in_pkt[3] = ur_in;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      if (LEVEL < A_W) begin : g_up
        localparam int HW = A_W - LEVEL;
        logic [HW-1:0] hi_addr;
        assign hi_addr   = in_pkt[gi][D_W+A_W-1:D_W+LEVEL];
        assign is_up[gi] = (hi_addr != HW'(POS));
      end else begin : g_top
        assign is_up[gi] = 1'b0;
      end
      assign dir[gi] = !in_pkt[gi][P_W-1]       ? DIR_VOID :
                       is_up[gi]                 ? DIR_UP   :
                       in_pkt[gi][D_W+LEVEL-1]   ? DIR_RIGHT : DIR_LEFT;
    end
  endgenerate

  logic [3:0]  taken;
  logic [3:0]  done;
  logic [1:0]  dest [4];
  logic [1:0]  sel  [4];
  logic [7:0]  pref;
  logic [1:0]  src;
  dir_t        want;
  dir_t        child;
  logic        up_step;
  logic [15:0] lfsr_reg;

  always_comb begin
    taken   = '0;
    done    = '0;
    pref    = '0;
    src     = '0;
    want    = DIR_VOID;
    child   = DIR_VOID;
    up_step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dest[i] = 2'd0;
      sel[i]  = 2'd0;
    end

    if (dir[0] == DIR_LEFT)  begin taken[0] = 1'b1; done[0] = 1'b1; dest[0] = 2'd0; end
    if (dir[1] == DIR_RIGHT) begin taken[1] = 1'b1; done[1] = 1'b1; dest[1] = 2'd1; end
    if (dir[2] == DIR_UP)    begin taken[2] = 1'b1; done[2] = 1'b1; dest[2] = 2'd2; end
    if (dir[3] == DIR_UP)    begin taken[3] = 1'b1; done[3] = 1'b1; dest[3] = 2'd3; end

    // Parents heading down: a blocked child sends them back up their own link.
    for (int c = 0; c < 2; c++) begin
      child = (c == 0) ? DIR_LEFT : DIR_RIGHT;
      if (!taken[c]) begin
        if (dir[2] == child) begin
          taken[c] = 1'b1; done[2] = 1'b1; dest[2] = 2'(c);
          if (dir[3] == child) begin taken[2] = 1'b1; done[3] = 1'b1; dest[3] = 2'd2; end
        end else if (dir[3] == child) begin
          taken[c] = 1'b1; done[3] = 1'b1; dest[3] = 2'(c);
        end
      end else begin
        if (dir[2] == child) begin taken[2] = 1'b1; done[2] = 1'b1; dest[2] = 2'd2; end
        if (dir[3] == child) begin taken[3] = 1'b1; done[3] = 1'b1; dest[3] = 2'd3; end
      end
    end

    // Child side links then uplinks; pref holds four output indices, first choice in the low bits.
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       begin src = 2'd0; want = DIR_RIGHT; pref = {2'd3, 2'd2, 2'd0, 2'd1}; end
        1:       begin src = 2'd1; want = DIR_LEFT;  pref = {2'd3, 2'd2, 2'd1, 2'd0}; end
        2:       begin src = 2'd0; want = DIR_UP;    pref = {2'd1, 2'd0, 2'd3, 2'd2}; end
        default: begin src = 2'd1; want = DIR_UP;    pref = {2'd0, 2'd1, 2'd3, 2'd2}; end
      endcase
      if (dir[src] == want) begin
        for (int k = 0; k < 4; k++) begin
          if (!done[src] && !taken[pref[2*k +: 2]]) begin
            taken[pref[2*k +: 2]] = 1'b1;
            done[src]             = 1'b1;
            dest[src]             = pref[2*k +: 2];
          end
        end
      end
    end

    for (int i = 0; i < 4; i++) begin
      if (dir[i] != DIR_VOID && dest[i][1]) up_step = 1'b1;
    end

    for (int i = 0; i < 4; i++) begin
      for (int o = 0; o < 4; o++) begin
        if (!done[i] && !taken[o]) begin
          taken[o] = 1'b1; done[i] = 1'b1; dest[i] = 2'(o);
        end
      end
    end

    for (int i = 0; i < 4; i++) sel[dest[i]] = 2'(i);
  end

  assign rnd = lfsr_reg[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_out    <= '0;
      r_out    <= '0;
      ul_out   <= '0;
      ur_out   <= '0;
      lfsr_reg <= LFSR_SEED;
    end else begin
      l_out  <= in_pkt[sel[0]];
      r_out  <= in_pkt[sel[1]];
      ul_out <= rnd ? in_pkt[sel[2]] : in_pkt[sel[3]];
      ur_out <= rnd ? in_pkt[sel[3]] : in_pkt[sel[2]];
      if (up_step)
        lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
  end

`ifdef PI_DEFLECT_STATS_EN
  logic [2:0]  defl_next;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_reg;
  logic        hit;

  always_comb begin
    defl_next = '0;
    hit       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      case (dir[i])
        DIR_UP:    hit = dest[i][1];
        DIR_LEFT:  hit = (dest[i] == 2'd0);
        DIR_RIGHT: hit = (dest[i] == 2'd1);
        default:   hit = 1'b1;
      endcase
      if (!hit) defl_next = defl_next + 3'd1;
    end
  end

  assign cnt_sum = {1'b0, cnt_reg} + 17'(defl_next);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_reg <= '0;
    else          cnt_reg <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  assign deflect_cnt = cnt_reg;
`else
  assign deflect_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pi_switch_node.sv
// Bench for pi_switch_node (LEVEL=1, POS=0): directed vector table, then a randomised stream
// checked against a reference router and a permutation check, with a mid-stream reset.
module tb_pi_switch_node;
  localparam int D_W = 32;
  localparam int A_W = 8;
  localparam int P_W = 1 + A_W + D_W;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int VD = 0, UPD = 1, LD = 2, RD = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic [P_W-1:0] l_in, r_in, ul_in, ur_in;
  logic [P_W-1:0] l_out, r_out, ul_out, ur_out;
  logic rnd;
  logic [15:0] deflect_cnt;

  pi_switch_node #(.D_W(D_W), .A_W(A_W), .LEVEL(1), .POS(0), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset_n(reset_n),
    .l_in(l_in), .r_in(r_in), .ul_in(ul_in), .ur_in(ur_in),
    .l_out(l_out), .r_out(r_out), .ul_out(ul_out), .ur_out(ur_out),
    .rnd(rnd), .deflect_cnt(deflect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [P_W-1:0] l, r, ul, ur;
    logic [P_W-1:0] el, er, eu1, eu2;
    bit             step;
    int             defl;
  } vec_t;

  typedef struct packed {
    logic [3:0][P_W-1:0] ins;
    logic [3:0][P_W-1:0] outs;
    logic                erd;
    logic [15:0]         ecnt;
  } exp_t;

  vec_t        tbl [15];
  exp_t        sbq [$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [15:0] tb_lfsr;
  logic [15:0] tb_cnt;

  function automatic logic [P_W-1:0] pk(input logic [7:0] a, input logic [31:0] p);
    return {1'b1, a, p};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int decode(input logic [P_W-1:0] p);
    logic [7:0] a;
    a = p[P_W-2 -: 8];
    if (!p[P_W-1])      return VD;
    if (a[7:1] != 7'd0) return UPD;
    return a[0] ? RD : LD;
  endfunction

  function automatic logic [3:0][P_W-1:0] srt(input logic [3:0][P_W-1:0] v);
    logic [P_W-1:0] t;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v;
  endfunction

  // Reference router: own[o] holds the input index granted output o (L, R, U1, U2).
  task automatic model(input logic [3:0][P_W-1:0] ip, output logic [3:0][P_W-1:0] op,
                       output bit stp, output int dfl);
    int dd[4], own[4], pref[4];
    int src, want, cd;
    bit placed;
    for (int i = 0; i < 4; i++) begin dd[i] = decode(ip[i]); own[i] = -1; end
    if (dd[0] == LD)  own[0] = 0;
    if (dd[1] == RD)  own[1] = 1;
    if (dd[2] == UPD) own[2] = 2;
    if (dd[3] == UPD) own[3] = 3;
    for (int c = 0; c < 2; c++) begin
      cd = (c == 0) ? LD : RD;
      if (dd[2] == cd && dd[3] == cd) begin
        if (own[c] < 0) begin own[c] = 2; own[2] = 3; end
        else begin own[2] = 2; own[3] = 3; end
      end else if (dd[2] == cd) begin
        if (own[c] < 0) own[c] = 2; else own[2] = 2;
      end else if (dd[3] == cd) begin
        if (own[c] < 0) own[c] = 3; else own[3] = 3;
      end
    end
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       begin src = 0; want = RD;  pref = '{1, 0, 2, 3}; end
        1:       begin src = 1; want = LD;  pref = '{0, 1, 2, 3}; end
        2:       begin src = 0; want = UPD; pref = '{2, 3, 0, 1}; end
        default: begin src = 1; want = UPD; pref = '{2, 3, 1, 0}; end
      endcase
      placed = 1'b0;
      if (dd[src] == want)
        for (int k = 0; k < 4; k++)
          if (!placed && own[pref[k]] < 0) begin own[pref[k]] = src; placed = 1'b1; end
    end
    stp = 1'b0;
    for (int o = 2; o < 4; o++) if (own[o] >= 0 && dd[own[o]] != VD) stp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      placed = 1'b0;
      for (int o = 0; o < 4; o++) if (own[o] == i) placed = 1'b1;
      for (int o = 0; o < 4; o++) if (!placed && own[o] < 0) begin own[o] = i; placed = 1'b1; end
    end
    dfl = 0;
    for (int o = 0; o < 4; o++) begin
      if (dd[own[o]] != VD &&
          !((o == 0 && dd[own[o]] == LD) || (o == 1 && dd[own[o]] == RD) || (o >= 2 && dd[own[o]] == UPD)))
        dfl++;
      op[o] = ip[own[o]];
    end
  endtask

  task automatic cmp(input string tag, input string fld, input logic [P_W-1:0] got, input logic [P_W-1:0] exp);
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s.%s vec=%0d got=%h exp=%h", tag, fld, n_vec, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    n_vec++;
    cmp(tag, "l_out", l_out, '0);
    cmp(tag, "r_out", r_out, '0);
    cmp(tag, "ul_out", ul_out, '0);
    cmp(tag, "ur_out", ur_out, '0);
    cmp(tag, "rnd", P_W'(rnd), P_W'(SEED[0]));
    cmp(tag, "deflect_cnt", P_W'(deflect_cnt), '0);
    $display("vec %0d %s: outs=%h/%h/%h/%h rnd=%b cnt=%0d", n_vec, tag, l_out, r_out, ul_out, ur_out, rnd, deflect_cnt);
  endtask

  // Called at a falling edge: drive, push the expectation, then compare after the next rising edge.
  task automatic apply(input logic [P_W-1:0] a, b, c, d, el, er, eu1, eu2,
                       input bit stp, input int dfl, input string tag);
    exp_t e, g;
    logic [16:0] s;
    l_in = a; r_in = b; ul_in = c; ur_in = d;
    e.ins     = {d, c, b, a};
    e.outs[0] = el;
    e.outs[1] = er;
    e.outs[2] = tb_lfsr[0] ? eu1 : eu2;
    e.outs[3] = tb_lfsr[0] ? eu2 : eu1;
    if (stp) tb_lfsr = lfsr_step(tb_lfsr);
    s = {1'b0, tb_cnt} + 17'(dfl);
    tb_cnt = s[16] ? 16'hFFFF : s[15:0];
    e.erd = tb_lfsr[0];
`ifdef PI_DEFLECT_STATS_EN
    e.ecnt = tb_cnt;
`else
    e.ecnt = 16'd0;
`endif
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    g = sbq.pop_front();
    n_vec++;
    cmp(tag, "l_out", l_out, g.outs[0]);
    cmp(tag, "r_out", r_out, g.outs[1]);
    cmp(tag, "ul_out", ul_out, g.outs[2]);
    cmp(tag, "ur_out", ur_out, g.outs[3]);
    cmp(tag, "rnd", P_W'(rnd), P_W'(g.erd));
    cmp(tag, "deflect_cnt", P_W'(deflect_cnt), P_W'(g.ecnt));
    if (srt({ur_out, ul_out, r_out, l_out}) !== srt(g.ins)) begin
      n_miss++;
      $display("FAIL %s.permutation vec=%0d got=%h/%h/%h/%h exp_set=%h", tag, n_vec, l_out, r_out, ul_out, ur_out, g.ins);
    end
    $display("vec %0d %s: in=%h/%h/%h/%h out=%h/%h/%h/%h rnd=%b cnt=%0d", n_vec, tag, a, b, c, d,
             l_out, r_out, ul_out, ur_out, rnd, deflect_cnt);
  endtask

  initial begin
    logic [3:0][P_W-1:0] ip, op;
    logic [7:0] ad;
    bit stp;
    int dfl;
    logic [P_W-1:0] z;
    z = '0;
    //              l                 r                  ul                 ur                 L   R   U1  U2  step defl
    tbl[0]  = '{z,                z,                 z,                 z,                 z, z, z, z, 0, 0};
    tbl[1]  = '{pk(8'h01,32'hDEADBEEF), z, z, z,       z, pk(8'h01,32'hDEADBEEF), z, z, 0, 0};
    tbl[2]  = '{z, z, pk(8'h00,32'hA0A0A0A0), pk(8'h00,32'hB0B0B0B0),
                pk(8'h00,32'hA0A0A0A0), z, pk(8'h00,32'hB0B0B0B0), z, 1, 1};
    tbl[3]  = '{pk(8'h00,32'hC0C0C0C0), pk(8'h00,32'hD0D0D0D0), z, z,
                pk(8'h00,32'hC0C0C0C0), pk(8'h00,32'hD0D0D0D0), z, z, 0, 1};
    tbl[4]  = '{pk(8'h10,32'hE0000001), z, z, z,       z, z, pk(8'h10,32'hE0000001), z, 1, 0};
    tbl[5]  = '{z, z, pk(8'h10,32'h5), pk(8'h20,32'h6), z, z, pk(8'h10,32'h5), pk(8'h20,32'h6), 1, 0};
    tbl[6]  = '{z, z, z, pk(8'h80,32'h7),              z, z, z, pk(8'h80,32'h7), 1, 0};
    tbl[7]  = '{pk(8'h10,32'hE0000002), z, z, z,       z, z, pk(8'h10,32'hE0000002), z, 1, 0};
    tbl[8]  = '{pk(8'h00,32'h81), z, pk(8'h00,32'h82), pk(8'h01,32'h83),
                pk(8'h00,32'h81), pk(8'h01,32'h83), pk(8'h00,32'h82), z, 1, 1};
    tbl[9]  = '{pk(8'h01,32'h91), pk(8'h00,32'h92), pk(8'h01,32'h93), z,
                pk(8'h01,32'h91), pk(8'h01,32'h93), pk(8'h00,32'h92), z, 1, 2};
    tbl[10] = '{pk(8'h10,32'hA1), pk(8'h20,32'hA2), pk(8'h40,32'hA3), pk(8'h80,32'hA4),
                pk(8'h10,32'hA1), pk(8'h20,32'hA2), pk(8'h40,32'hA3), pk(8'h80,32'hA4), 1, 2};
    tbl[11] = '{z, pk(8'h01,32'hB1), z, z,             z, pk(8'h01,32'hB1), z, z, 0, 0};
    tbl[12] = '{pk(8'h10,32'hC1), z, pk(8'h40,32'hC2), z,
                z, z, pk(8'h40,32'hC2), pk(8'h10,32'hC1), 1, 0};
    tbl[13] = '{z, pk(8'h02,32'hD1), z, z,             z, z, pk(8'h02,32'hD1), z, 1, 0};
    tbl[14] = '{pk(8'h10,32'hE1), pk(8'hFE,32'hE2), z, z,
                z, z, pk(8'h10,32'hE1), pk(8'hFE,32'hE2), 1, 0};

    reset_n = 1'b0;
    l_in = '0; r_in = '0; ul_in = '0; ur_in = '0;
    tb_lfsr = SEED;
    tb_cnt  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_hold");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++)
      apply(tbl[i].l, tbl[i].r, tbl[i].ul, tbl[i].ur, tbl[i].el, tbl[i].er, tbl[i].eu1, tbl[i].eu2,
            tbl[i].step, tbl[i].defl, $sformatf("table%0d", i));

    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        #2 reset_n = 1'b0;
        #1 check_reset("reset_mid");
        sbq.delete();
        tb_lfsr = SEED;
        tb_cnt  = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 2))
          0:       ad = 8'h00;
          1:       ad = 8'h01;
          default: ad = 8'($urandom);
        endcase
        ip[k] = {($urandom_range(0, 7) != 0), ad, 32'($urandom)};
      end
      model(ip, op, stp, dfl);
      apply(ip[0], ip[1], ip[2], ip[3], op[0], op[1], op[2], op[3], stp, dfl, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
